// File: rtl/periferico_divisor_n_if.sv
// periferico_divisor_n_if
// Calculator-bus bundle shared by the divider peripheral and whoever drives it.
//   cs     chip select
//   rd     read strobe, meaningful only with cs
//   wr     write strobe, meaningful only with cs
//   addr   5-bit register address
//   d_in   WIDTH-bit write data
//   d_out  WIDTH-bit registered read data (driven by the peripheral)
// Modports: master drives the strobes/address/data, slave returns d_out.
interface periferico_divisor_n_if #(
  parameter int WIDTH = 16
);
  logic             cs;
  logic             rd;
  logic             wr;
  logic [4:0]       addr;
  logic [WIDTH-1:0] d_in;
  logic [WIDTH-1:0] d_out;

  modport master (output cs, rd, wr, addr, d_in, input d_out);
  modport slave  (input cs, rd, wr, addr, d_in, output d_out);
endinterface

// File: rtl/periferico_divisor_n.sv
// periferico_divisor_n
// Memory-mapped restoring shift-subtract divider, one quotient bit per clock.
// Registers: 0x04 DV, 0x08 DR, 0x0C CTRL (bit0 START, bit1 SIGNED),
//            0x10 Q, 0x14 REM, 0x18 STATUS (bit0 DONE, bit1 BUSY, bit2 DIV0).
// Ports:
//   CLK    system clock, rising edge
//   reset  asynchronous, active-low reset
//   bus    periferico_divisor_n_if slave modport (cs/rd/wr/addr/d_in/d_out)
// Parameter WIDTH (4..32) sets operand, result and data-bus width.
// Optional feature macro DIVISOR_SIGNED_EN: when defined, CTRL bit1 selects
// signed division; when undefined all operations are unsigned.
module periferico_divisor_n #(
  parameter int WIDTH = 16
) (
  input logic                 CLK,
  input logic                 reset,
  periferico_divisor_n_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [4:0] ADDR_DV     = 5'h04;
  localparam logic [4:0] ADDR_DR     = 5'h08;
  localparam logic [4:0] ADDR_CTRL   = 5'h0C;
  localparam logic [4:0] ADDR_Q      = 5'h10;
  localparam logic [4:0] ADDR_REM    = 5'h14;
  localparam logic [4:0] ADDR_STATUS = 5'h18;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] dv_reg;
  logic [WIDTH-1:0] dr_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] rem_reg;
  logic             done;
  logic             busy;
  logic             div0;
  logic             div0_pend;
  logic [WIDTH-1:0] work_rem;
  logic [WIDTH-1:0] work_quo;
  logic [WIDTH-1:0] work_div;
  logic [CNT_W-1:0] count;

  logic             wr_en;
  logic             rd_en;
  logic             start_req;
  logic [WIDTH-1:0] rd_data;
  logic [WIDTH-1:0] dv_mag;
  logic [WIDTH-1:0] dr_mag;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] rem_fix;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  assign wr_en     = bus.cs & bus.wr;
  assign rd_en     = bus.cs & bus.rd;
  // START outside IDLE (RUN or FIX) is dropped without touching any flag
  assign start_req = wr_en && (bus.addr == ADDR_CTRL) && bus.d_in[0] && (state == S_IDLE);

`ifdef DIVISOR_SIGNED_EN
  logic op_signed;
  logic neg_q;
  logic neg_r;

  // Magnitudes are taken when the operands are latched; the most negative
  // value maps onto itself, which is the correct unsigned magnitude.
  assign op_signed = bus.d_in[1];
  assign dv_mag    = (op_signed && dv_reg[WIDTH-1]) ? -dv_reg : dv_reg;
  assign dr_mag    = (op_signed && dr_reg[WIDTH-1]) ? -dr_reg : dr_reg;
  assign q_fix     = neg_q ? -work_quo : work_quo;
  assign rem_fix   = neg_r ? -work_rem : work_rem;
`else
  assign dv_mag  = dv_reg;
  assign dr_mag  = dr_reg;
  assign q_fix   = work_quo;
  assign rem_fix = work_rem;
`endif

  // One restoring step: the partial remainder is always below the divisor,
  // so the shifted value fits in WIDTH+1 bits and diff[WIDTH] is the borrow.
  assign shifted = {work_rem, work_quo[WIDTH-1]};
  assign diff    = shifted - {1'b0, work_div};

  always_comb begin
    rd_data = '0;
    case (bus.addr)
      ADDR_DV:     rd_data = dv_reg;
      ADDR_DR:     rd_data = dr_reg;
      ADDR_Q:      rd_data = q_reg;
      ADDR_REM:    rd_data = rem_reg;
      ADDR_STATUS: rd_data = {{(WIDTH-3){1'b0}}, div0, busy, done};
      default:     rd_data = '0;
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      bus.d_out <= '0;
      dv_reg    <= '0;
      dr_reg    <= '0;
      q_reg     <= '0;
      rem_reg   <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
      div0      <= 1'b0;
      div0_pend <= 1'b0;
      work_rem  <= '0;
      work_quo  <= '0;
      work_div  <= '0;
      count     <= '0;
`ifdef DIVISOR_SIGNED_EN
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
`endif
    end else begin
      // Read data comes from the pre-edge register values, so a combined
      // read+write of the same register returns the old contents.
      bus.d_out <= rd_en ? rd_data : '0;

      if (wr_en && (bus.addr == ADDR_DV)) dv_reg <= bus.d_in;
      if (wr_en && (bus.addr == ADDR_DR)) dr_reg <= bus.d_in;

      case (state)
        S_IDLE: begin
          if (start_req) begin
            done     <= 1'b0;
            div0     <= 1'b0;
            busy     <= 1'b1;
            work_rem <= '0;
            work_div <= dr_mag;
            count    <= CNT_W'(WIDTH - 1);
`ifdef DIVISOR_SIGNED_EN
            neg_q    <= op_signed & (dv_reg[WIDTH-1] ^ dr_reg[WIDTH-1]);
            neg_r    <= op_signed & dv_reg[WIDTH-1];
`endif
            // On divide-by-zero the raw dividend is parked in work_quo so
            // FIX can report it unchanged as the remainder.
            if (dr_reg == '0) begin
              div0_pend <= 1'b1;
              work_quo  <= dv_reg;
              state     <= S_FIX;
            end else begin
              div0_pend <= 1'b0;
              work_quo  <= dv_mag;
              state     <= S_RUN;
            end
          end
        end

        S_RUN: begin
          if (!diff[WIDTH]) begin
            work_rem <= diff[WIDTH-1:0];
            work_quo <= {work_quo[WIDTH-2:0], 1'b1};
          end else begin
            work_rem <= shifted[WIDTH-1:0];
            work_quo <= {work_quo[WIDTH-2:0], 1'b0};
          end
          if (count == '0) begin
            state <= S_FIX;
          end else begin
            count <= count - 1'b1;
          end
        end

        S_FIX: begin
          if (div0_pend) begin
            q_reg   <= '1;
            rem_reg <= work_quo;
            div0    <= 1'b1;
          end else begin
            q_reg   <= q_fix;
            rem_reg <= rem_fix;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/periferico_divisor_n.md
# periferico_divisor_n

Parametrised memory-mapped divider peripheral, successor to the fixed 16-bit divider on the calculator bus.
- Computes quotient and remainder of a WIDTH-bit dividend by a WIDTH-bit divisor using restoring shift-subtract, one quotient bit per cycle.
- Adds a remainder register, a status register with divide-by-zero and busy flags, and optional signed mode.
- Sits on the same cs/rd/wr/addr bus as the other calculator cores.

## Interface
- WIDTH, 16, operand/result/data-bus width (4..32).
- CLK  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cs  in  1  chip select.
- rd  in  1  read strobe, qualified by cs.
- wr  in  1  write strobe, qualified by cs.
- addr  in  5  register address.
- d_in  in  WIDTH  write data.
- d_out  out  WIDTH  read data, registered.

## Operation
Register map:
- 0x04 DV: dividend, R/W.
- 0x08 DR: divisor, R/W.
- 0x0C CTRL: write only.
  - bit0 START (self-clearing).
  - bit1 SIGNED (latched with START).
  - Reads return 0.
- 0x10 Q: quotient, RO.
- 0x14 REM: remainder, RO.
- 0x18 STATUS, RO: bit0 DONE, bit1 BUSY, bit2 DIV0; other bits 0.
- Unmapped addresses: reads return 0, writes ignored.

State machine IDLE -> RUN -> FIX -> IDLE:
- **IDLE**
  - A write to CTRL with bit0=1 latches DV, DR and SIGNED into working registers, clears DONE and DIV0, and sets BUSY.
  - If DR=0: goes to FIX with DIV0 pending.
  - Otherwise: goes to RUN with iteration counter = WIDTH-1.
- **RUN**
  - Each cycle: shift {rem, dividend} left 1 and trial-subtract the divisor; if no borrow, keep the difference and shift in quotient bit 1.
  - When the counter reaches 0, go to FIX.
- **FIX**
  - Apply sign correction and write Q/REM; set DONE; clear BUSY; return to IDLE.

Arithmetic and boundary rules:
- Unsigned: Q = DV/DR, REM = DV mod DR.
- Signed: operand magnitudes are taken at latch time.
  - Quotient truncates toward zero and is negated when the operand signs differ.
  - Remainder takes the dividend's sign.
  - -2^(WIDTH-1) / -1 gives Q = -2^(WIDTH-1) (wraps) and REM = 0.
- Divide by zero (either mode): Q = all ones, REM = latched DV, DIV0 = 1, DONE = 1.
- Q/REM hold their last result until the next FIX.
- DONE is sticky until the next accepted START or reset.
- START while BUSY is ignored: no restart, no flag change.
- DV/DR writes while BUSY update the registers but do not affect the running operation.
- cs with rd and wr both high: the write is performed, and d_out loads the pre-write value.
- Reset asserted mid-operation:
  - Aborts immediately and returns to IDLE.
  - All registers, flags and d_out are cleared to 0.

## Timing
- Reset values: d_out=0, DV=DR=Q=REM=0, DONE=BUSY=DIV0=0, state IDLE.
- Writes take effect at the rising edge where cs&wr is sampled high.
- Reads are registered:
  - If cs&rd is high at edge N, d_out holds the selected register from edge N until the next edge.
  - Otherwise d_out is loaded with 0.
- Division latency, counting the START-write edge as T0:
  - BUSY is visible after T0.
  - RUN occupies T1..T(WIDTH).
  - FIX at T(WIDTH+1) sets DONE, so DONE rises WIDTH+1 edges after T0 (17 for WIDTH=16).
- Divide by zero: DONE and DIV0 rise at T1.
- A new START is accepted on the edge right after DONE rises.

## Configuration
- DIVISOR_SIGNED_EN defined:
  - CTRL bit1 selects signed mode.
  - Magnitude and sign-correction logic is compiled in.
- DIVISOR_SIGNED_EN undefined:
  - CTRL bit1 is ignored and all operations are unsigned.
  - No sign logic is synthesised.
  - Divide-by-zero and status behaviour are unchanged.

## Test plan
- WIDTH=16 unsigned, 900/5:
  - DONE rises exactly 17 edges after the START edge.
  - Q=180, REM=0, STATUS=0x1.
- 1000/7: Q=142, REM=6. Then 0xFFFF/0x0001: Q=0xFFFF, REM=0.
- 55/0:
  - DONE at T1.
  - Q=0xFFFF, REM=55, STATUS=0x5.
  - Next START with 10/3 clears DIV0: Q=3, REM=1.
- With DIVISOR_SIGNED_EN and SIGNED=1:
  - -7/2 gives Q=0xFFFD, REM=0xFFFF.
  - 0x8000/0xFFFF gives Q=0x8000, REM=0.
- Write START for 900/5:
  - A second START at T3 is ignored: result stays 180.
  - In another run, reset pulsed low at T8 leaves all registers and STATUS at 0.
- WIDTH=8 instance, 200/3: Q=66, REM=2, DONE after 9 edges.
